// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple segment per stage,
// with skewed operands and deskewed sum chunks so a whole result exits at once.

module pipe_adder_checker #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_sum,
    input logic             out_cout,
    input logic             out_ovf
);

    a_ready_is_advance: assert property (@(posedge clk) disable iff (rst)
        in_ready == (!out_valid || out_ready));

    // A result waiting on the consumer must neither change nor disappear.
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
        (out_valid && $stable(out_sum) && $stable(out_cout) && $stable(out_ovf)));

endmodule

module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        chunk_add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Index k is what stage k consumes. The A vector carries finished sum
    // chunks below chunk k and untouched operand chunks from chunk k upward.
    logic [WIDTH-1:0] st_a_s [STAGES];
    logic [WIDTH-1:0] st_b_s [STAGES];
    logic             st_c_s [STAGES];
    logic             st_v_s [STAGES];

    logic             en_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;
    logic             out_ovf_r;

    assign en_s     = !out_valid_r || out_ready;
    assign in_ready = en_s;

    assign st_a_s[0] = in_a;
    assign st_b_s[0] = in_sub ? ~in_b : in_b;
    assign st_c_s[0] = in_sub ? 1'b1 : in_cin;
    assign st_v_s[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        logic [CHUNK:0]   csum_s;
        logic [WIDTH-1:0] merged_s;

        // Sum this stage's chunk and splice it into the travelling vector.
        always_comb begin
            csum_s              = chunk_add(st_a_s[k][LO +: CHUNK], st_b_s[k][LO +: CHUNK], st_c_s[k]);
            merged_s            = st_a_s[k];
            merged_s[LO +: CHUNK] = csum_s[CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic             c_r;
            logic             v_r;

            // Intermediate stage register; shifts only on global advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_r <= 1'b0;
                    a_r <= {WIDTH{1'b0}};
                    b_r <= {WIDTH{1'b0}};
                    c_r <= 1'b0;
                end else if (en_s) begin
                    v_r <= st_v_s[k];
                    a_r <= merged_s;
                    b_r <= st_b_s[k];
                    c_r <= csum_s[CHUNK];
                end
            end

            assign st_a_s[k+1] = a_r;
            assign st_b_s[k+1] = b_r;
            assign st_c_s[k+1] = c_r;
            assign st_v_s[k+1] = v_r;
        end else begin : g_last
            logic msb_cin_s;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign msb_cin_s = st_a_s[k][WIDTH-1] ^ st_b_s[k][WIDTH-1] ^ csum_s[CHUNK-1];

            // Output register; data only reloads on a valid beat so it keeps its last value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    out_sum_r   <= {WIDTH{1'b0}};
                    out_cout_r  <= 1'b0;
                    out_ovf_r   <= 1'b0;
                end else if (en_s) begin
                    out_valid_r <= st_v_s[k];
                    if (st_v_s[k]) begin
                        out_sum_r  <= merged_s;
                        out_cout_r <= csum_s[CHUNK];
                        out_ovf_r  <= msb_cin_s ^ csum_s[CHUNK];
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign out_ovf   = out_ovf_r;

    pipe_adder_checker #(.WIDTH(WIDTH)) u_checker (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_sum   (out_sum_r),
        .out_cout  (out_cout_r),
        .out_ovf   (out_ovf_r)
    );

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed table on an 8/4 instance plus random
// scoreboarded runs on 32/8 and 16/16 instances.

module tb_pipe_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       p8_in_valid, p8_in_ready, p8_in_cin, p8_in_sub;
    logic [7:0] p8_in_a, p8_in_b, p8_out_sum;
    logic       p8_out_valid, p8_out_ready, p8_out_cout, p8_out_ovf;

    logic        p32_in_valid, p32_in_ready, p32_in_cin, p32_in_sub;
    logic [31:0] p32_in_a, p32_in_b, p32_out_sum;
    logic        p32_out_valid, p32_out_ready, p32_out_cout, p32_out_ovf;

    logic        p16_in_valid, p16_in_ready, p16_in_cin, p16_in_sub;
    logic [15:0] p16_in_a, p16_in_b, p16_out_sum;
    logic        p16_out_valid, p16_out_ready, p16_out_cout, p16_out_ovf;

    pipe_adder #(.WIDTH(8), .CHUNK(4)) d8 (
        .clk(clk), .rst(rst), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
        .in_a(p8_in_a), .in_b(p8_in_b), .in_cin(p8_in_cin), .in_sub(p8_in_sub),
        .out_valid(p8_out_valid), .out_ready(p8_out_ready), .out_sum(p8_out_sum),
        .out_cout(p8_out_cout), .out_ovf(p8_out_ovf));

    pipe_adder #(.WIDTH(32), .CHUNK(8)) d32 (
        .clk(clk), .rst(rst), .in_valid(p32_in_valid), .in_ready(p32_in_ready),
        .in_a(p32_in_a), .in_b(p32_in_b), .in_cin(p32_in_cin), .in_sub(p32_in_sub),
        .out_valid(p32_out_valid), .out_ready(p32_out_ready), .out_sum(p32_out_sum),
        .out_cout(p32_out_cout), .out_ovf(p32_out_ovf));

    pipe_adder #(.WIDTH(16), .CHUNK(16)) d16 (
        .clk(clk), .rst(rst), .in_valid(p16_in_valid), .in_ready(p16_in_ready),
        .in_a(p16_in_a), .in_b(p16_in_b), .in_cin(p16_in_cin), .in_sub(p16_in_sub),
        .out_valid(p16_out_valid), .out_ready(p16_out_ready), .out_sum(p16_out_sum),
        .out_cout(p16_out_cout), .out_ovf(p16_out_ovf));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t tbl [12];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum} using sign-bit overflow rules.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input int w);
        logic [32:0] mask, full;
        logic [31:0] bx, s;
        logic [5:0]  wi;
        logic        c, o;
        wi   = w[5:0];
        mask = (33'd1 << wi) - 33'd1;
        bx   = sub ? ~b : b;
        full = ({1'b0, a} & mask) + ({1'b0, bx} & mask) + {32'd0, (sub ? 1'b1 : cin)};
        s    = full[31:0] & mask[31:0];
        c    = full[wi];
        o    = (a[wi-6'd1] == bx[wi-6'd1]) && (s[wi-6'd1] != a[wi-6'd1]);
        return {o, c, s};
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input logic v);
        p8_in_a = a; p8_in_b = b; p8_in_cin = cin; p8_in_sub = sub; p8_in_valid = v;
    endtask

    logic [7:0]  ba [16], bb [16];
    logic        bc [16], bs [16];
    logic [33:0] bexp [16];
    logic [33:0] sexp [3];
    logic [33:0] q32 [$];
    logic [33:0] q16 [$];
    logic [33:0] held32, held16;
    logic        hold32, hold16;
    int          lat, k, w2;
    logic        got;

    initial begin
        tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
        tbl[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4]  = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[5]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[10] = '{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1};
        tbl[11] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};

        rst = 1'b1;
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        p8_out_ready = 1'b1;
        p32_in_valid = 1'b0; p32_in_a = 32'd0; p32_in_b = 32'd0; p32_in_cin = 1'b0;
        p32_in_sub = 1'b0; p32_out_ready = 1'b1;
        p16_in_valid = 1'b0; p16_in_a = 16'd0; p16_in_b = 16'd0; p16_in_cin = 1'b0;
        p16_in_sub = 1'b0; p16_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", p8_out_valid, 1'b0);
        check("reset_out_sum", p8_out_sum, 8'h00);
        check("reset_out_cout", p8_out_cout, 1'b0);
        check("reset_out_ovf", p8_out_ovf, 1'b0);
        check("reset_in_ready", p8_in_ready, 1'b1);

        // Directed table, one transaction at a time, with latency measurement.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1);
            @(negedge clk);
            check($sformatf("dir%0d_in_ready", i), p8_in_ready, 1'b1);
            @(posedge clk); #1;
            p8_in_valid = 1'b0;
            lat = 0; got = 1'b0;
            while (!got && lat < 10) begin
                @(negedge clk);
                lat++;
                if (p8_out_valid) got = 1'b1;
            end
            check($sformatf("dir%0d_latency", i), lat, 2);
            check($sformatf("dir%0d_sum", i), p8_out_sum, tbl[i].sum);
            check($sformatf("dir%0d_cout", i), p8_out_cout, tbl[i].cout);
            check($sformatf("dir%0d_ovf", i), p8_out_ovf, tbl[i].ovf);
        end

        // Back-to-back stream of 16.
        for (int i = 0; i < 16; i++) begin
            ba[i] = 8'($urandom); bb[i] = 8'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom);
            bexp[i] = model({24'd0, ba[i]}, {24'd0, bb[i]}, bc[i], bs[i], 8);
        end
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk); #1;
                    drive8(ba[i], bb[i], bc[i], bs[i], 1'b1);
                end
                @(posedge clk); #1;
                p8_in_valid = 1'b0;
            end
            begin
                for (int n = 1; n <= 20; n++) begin
                    @(negedge clk);
                    if (n >= 3 && n <= 18) begin
                        check($sformatf("btb%0d_valid", n - 3), p8_out_valid, 1'b1);
                        check($sformatf("btb%0d_result", n - 3),
                              {p8_out_ovf, p8_out_cout, 24'd0, p8_out_sum}, bexp[n - 3]);
                    end else begin
                        check($sformatf("btb_idle_n%0d", n), p8_out_valid, 1'b0);
                    end
                end
            end
        join

        // Stall: three transactions, consumer blocked for five cycles.
        sexp[0] = model(32'h11, 32'h22, 1'b0, 1'b0, 8);
        sexp[1] = model(32'h90, 32'h25, 1'b0, 1'b1, 8);
        sexp[2] = model(32'hE7, 32'h3C, 1'b1, 1'b0, 8);
        p8_out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int w;
                    @(posedge clk); #1;
                    drive8(8'(sexp[i] == sexp[i] ? (i == 0 ? 8'h11 : (i == 1 ? 8'h90 : 8'hE7)) : 8'h00),
                           (i == 0 ? 8'h22 : (i == 1 ? 8'h25 : 8'h3C)),
                           (i == 2), (i == 1), 1'b1);
                    @(negedge clk);
                    w = 0;
                    while (!p8_in_ready && w < 30) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 30) check("stall_accept_timeout", w, 0);
                end
                @(posedge clk); #1;
                p8_in_valid = 1'b0;
            end
            begin
                w2 = 0;
                do begin
                    @(negedge clk);
                    w2++;
                end while (!p8_out_valid && w2 < 20);
                check("stall_fill_valid", p8_out_valid, 1'b1);
                for (int j = 0; j < 5; j++) begin
                    check($sformatf("stall%0d_in_ready", j), p8_in_ready, 1'b0);
                    check($sformatf("stall%0d_held", j),
                          {p8_out_valid, p8_out_ovf, p8_out_cout, 24'd0, p8_out_sum}, {1'b1, sexp[0]});
                    if (j < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                p8_out_ready = 1'b1;
                k = 0;
                for (int j = 0; j < 8; j++) begin
                    @(negedge clk);
                    if (p8_out_valid) begin
                        if (k < 3)
                            check($sformatf("stall_result%0d", k),
                                  {p8_out_ovf, p8_out_cout, 24'd0, p8_out_sum}, sexp[k]);
                        k++;
                    end
                end
                check("stall_result_count", k, 3);
            end
        join

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        drive8(8'h21, 8'h43, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive8(8'h65, 8'h87, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("rst_pre_valid", p8_out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_out_valid", p8_out_valid, 1'b0);
        check("rst_out_data", {p8_out_ovf, p8_out_cout, p8_out_sum}, 10'd0);
        p8_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("rst_after%0d_valid", j), p8_out_valid, 1'b0);
        end
        check("rst_after_in_ready", p8_in_ready, 1'b1);

        // Random handshakes on 32/8 and 16/16, then a drain.
        hold32 = 1'b0; hold16 = 1'b0;
        for (int c = 0; c < 1020; c++) begin
            @(posedge clk); #1;
            p32_in_a = $urandom; p32_in_b = $urandom;
            p32_in_cin = 1'($urandom); p32_in_sub = 1'($urandom);
            p16_in_a = 16'($urandom); p16_in_b = 16'($urandom);
            p16_in_cin = 1'($urandom); p16_in_sub = 1'($urandom);
            if (c < 1000) begin
                p32_in_valid = 1'($urandom); p32_out_ready = 1'($urandom);
                p16_in_valid = 1'($urandom); p16_out_ready = 1'($urandom);
            end else begin
                p32_in_valid = 1'b0; p32_out_ready = 1'b1;
                p16_in_valid = 1'b0; p16_out_ready = 1'b1;
            end
            @(negedge clk);
            if (hold32)
                check("r32_hold", {p32_out_valid, p32_out_ovf, p32_out_cout, p32_out_sum}, {1'b1, held32});
            hold32 = p32_out_valid && !p32_out_ready;
            held32 = {p32_out_ovf, p32_out_cout, p32_out_sum};
            if (p32_out_valid && p32_out_ready) begin
                if (q32.size() == 0) check("r32_underflow", q32.size(), 1);
                else check("r32_result", {p32_out_ovf, p32_out_cout, p32_out_sum}, q32.pop_front());
            end
            if (p32_in_valid && p32_in_ready)
                q32.push_back(model(p32_in_a, p32_in_b, p32_in_cin, p32_in_sub, 32));

            if (hold16)
                check("r16_hold", {p16_out_valid, p16_out_ovf, p16_out_cout, 16'd0, p16_out_sum}, {1'b1, held16});
            hold16 = p16_out_valid && !p16_out_ready;
            held16 = {p16_out_ovf, p16_out_cout, 16'd0, p16_out_sum};
            if (p16_out_valid && p16_out_ready) begin
                if (q16.size() == 0) check("r16_underflow", q16.size(), 1);
                else check("r16_result", {p16_out_ovf, p16_out_cout, 16'd0, p16_out_sum}, q16.pop_front());
            end
            if (p16_in_valid && p16_in_ready)
                q16.push_back(model({16'd0, p16_in_a}, {16'd0, p16_in_b}, p16_in_cin, p16_in_sub, 16));
        end
        check("r32_leftover", q32.size(), 0);
        check("r16_leftover", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined adder/subtractor with valid/ready handshakes on both sides. It generalises the single-bit full-adder cell to a WIDTH-bit operation split into CHUNK-bit ripple segments, one segment per pipeline stage, and adds carry-in, carry-out, signed overflow and an add/subtract mode. It sits between operand producers and result consumers in datapaths that need full throughput at high clock rates.

## Interface

- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits summed per stage; STAGES = WIDTH/CHUNK (1 allowed).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- out_ovf  out  1  signed two's-complement overflow.

## Operation

- Stage k (k = 0..STAGES−1) adds chunk k of A and B' (B' = in_sub ? ~B : B) plus carry from stage k−1; stage 0 uses in_sub ? 1 : in_cin.
- Operand chunks not yet consumed travel forward in skew registers; completed sum chunks travel forward in deskew registers, so all chunks of one transaction exit together.
- Each stage has a valid bit. Global advance: en = !out_valid | out_ready. in_ready = en (combinational from out_valid/out_ready; no dependence on in_valid).
- When en=1 all stage registers shift one place; the stage-0 valid loads in_valid. When en=0 all registers hold.
- Bubbles are not compressed: an empty stage moves forward like a full one.
- Final stage holds out_sum, out_cout = carry out of bit WIDTH−1, out_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Outputs are registers; out_sum/out_cout/out_ovf are held stable while out_valid=1 and out_ready=0.
- Data registers may hold arbitrary values while their valid bit is 0, except the output registers, which keep their last value.

## Timing

- Reset (async assert, released synchronously by the environment): all valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1 from the first cycle after reset.
- Latency: transaction accepted in cycle t (in_valid & in_ready) gives out_valid=1 in cycle t+STAGES, assuming no stall.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 → in_ready=0 the same cycle; no transaction is dropped or duplicated; at most STAGES transactions are in flight.
- Simultaneous output handshake and input: when out_valid & out_ready and in_valid in the same cycle, both transfers complete on that edge.
- Reset mid-operation: all in-flight transactions are discarded immediately; no result emerges after reset.
- Critical path: one CHUNK-bit ripple plus carry mux; no combinational path from in_* data to out_*.

## Test plan

- WIDTH=8, CHUNK=4: add A=0xFF, B=0x01, cin=0 → after 2 cycles out_sum=0x00, cout=1, ovf=0.
- Add A=0x7F, B=0x01, cin=1 → out_sum=0x81, cout=0, ovf=1; subtract A=0x05, B=0x07 → 0xFE, cout=0, ovf=0; subtract A=0x80, B=0x01 → 0x7F, cout=1, ovf=1.
- Back-to-back stream of 16 random transactions with out_ready=1 → 16 results in order on consecutive cycles, first at t+STAGES, each matching the reference model.
- Stall: 3 transactions in, out_ready=0 for 5 cycles → in_ready drops once the pipeline is full, out_* held stable; on release, exactly 3 results in order.
- Random in_valid/out_ready (50%) for 1000 cycles, WIDTH=32 CHUNK=8 and WIDTH=16 CHUNK=16 → scoreboard matches, no loss or duplicate.
- Assert rst with 2 transactions in flight → out_valid=0 and all outputs 0 immediately; no stale result appears after release.
